// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The slave modport is the LSU view; master is whoever drives the core
// inputs and models the memory.
interface load_store_unit_if;
  // core -> LSU
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  // LSU -> core
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        access_fault;
  // LSU <-> data memory
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  start, is_store, funct3, addr, store_data, mem_ready, mem_rdata,
    output stall, done, load_data, misaligned, illegal, access_fault,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output start, is_store, funct3, addr, store_data, mem_ready, mem_rdata,
    input  stall, done, load_data, misaligned, illegal, access_fault,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one memory transaction per accepted op over a
// req/ready handshake, with alignment/width checks and a request timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter only has to reach TIMEOUT_CYCLES-1; the expiring cycle is
  // detected by comparison rather than by counting one further.
  localparam int unsigned   CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] WAIT_LAST = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic          is_store_q, is_store_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          misaligned_q, misaligned_d;
  logic          illegal_q, illegal_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] wait_q, wait_d;

  logic          acc_illegal, acc_misaligned;
  logic [3:0]    acc_wstrb;
  logic [31:0]   acc_wdata;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_ext;

  // Decode the incoming op: legality, alignment, and store lane strobes/data.
  always_comb begin
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: acc_illegal = 1'b0;
      3'b100, 3'b101:         acc_illegal = bus.is_store;  // LBU/LHU have no store form
      default:                acc_illegal = 1'b1;
    endcase
    acc_misaligned = 1'b0;
    if (!acc_illegal) begin
      case (bus.funct3[1:0])
        2'b01:   acc_misaligned = bus.addr[0];
        2'b10:   acc_misaligned = |bus.addr[1:0];
        default: acc_misaligned = 1'b0;
      endcase
    end
    acc_wstrb = 4'b0000;
    acc_wdata = 32'h0;
    if (bus.is_store) begin
      case (bus.funct3[1:0])
        2'b00: begin
          acc_wstrb = 4'b0001 << bus.addr[1:0];
          acc_wdata = {4{bus.store_data[7:0]}};
        end
        2'b01: begin
          acc_wstrb = 4'b0011 << {bus.addr[1], 1'b0};
          acc_wdata = {2{bus.store_data[15:0]}};
        end
        default: begin
          acc_wstrb = 4'b1111;
          acc_wdata = bus.store_data;
        end
      endcase
    end
  end

  // Pick the addressed lane of the read word and extend it per funct3.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = bus.mem_rdata[7:0];
      2'd1:    rd_byte = bus.mem_rdata[15:8];
      2'd2:    rd_byte = bus.mem_rdata[23:16];
      default: rd_byte = bus.mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = bus.mem_rdata;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for ready or timeout in REQ,
  // single completion cycle in DONE.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    fault_d      = fault_q;
    wait_d       = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_store_d   = bus.is_store;
          funct3_d     = bus.funct3;
          addr_d       = bus.addr;
          wstrb_d      = acc_wstrb;
          wdata_d      = acc_wdata;
          load_data_d  = 32'h0;
          illegal_d    = acc_illegal;
          misaligned_d = acc_misaligned;
          fault_d      = 1'b0;
          wait_d       = '0;
          state_d      = (acc_illegal || acc_misaligned) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // Ready wins over an expiring counter in the same cycle.
        if (bus.mem_ready) begin
          if (!is_store_q) load_data_d = rd_ext;
          state_d = S_DONE;
        end else if (TMO_EN && (wait_q == WAIT_LAST)) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; async reset returns everything to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wstrb_q      <= 4'b0000;
      wdata_q      <= 32'h0;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      fault_q      <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      fault_q      <= fault_d;
      wait_q       <= wait_d;
    end
  end

  // Outputs decode straight from state so reset drops them without a clock.
  always_comb begin
    bus.stall        = ((state_q == S_IDLE) && bus.start) || (state_q == S_REQ);
    bus.done         = (state_q == S_DONE);
    bus.mem_req      = (state_q == S_REQ);
    bus.mem_we       = (state_q == S_REQ) && is_store_q;
    bus.mem_addr     = {addr_q[31:2], 2'b00};
    bus.mem_wstrb    = wstrb_q;
    bus.mem_wdata    = wdata_q;
    bus.load_data    = load_data_q;
    bus.misaligned   = misaligned_q;
    bus.illegal      = illegal_q;
    bus.access_fault = fault_q;
  end

endmodule
